ospfb_phase_sequencer: RTL and testbench

//  Runtime-configurable frame/phase sequencer for the oversampled PFB datapath; passes the sample stream through unchanged.

---
 rtl/ospfb_phase_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_ospfb_phase_sequencer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ospfb_phase_sequencer.sv
// Frame/phase sequencer for the oversampled PFB datapath.
// Registers the sample stream unchanged and tags every beat with its position
// inside the current decimation window, the frame count and the circular-shift
// offset (k*D mod M) needed to phase-correct the FFT input. M and D may be
// changed at run time; a new pair is held pending and only takes effect at a
// frame boundary, so frames are never truncated.
module ospfb_phase_sequencer #(
    parameter int WIDTH        = 16,
    parameter int SAMP_PER_CLK = 2,
    parameter int MAX_FFT_LEN  = 4096,
    parameter int DEF_FFT_LEN  = 2048,
    parameter int DEF_DEC_FAC  = 1536,
    parameter int FCNT_W       = 16,
    localparam int LEN_W       = $clog2(MAX_FFT_LEN) + 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [LEN_W-1:0]                cfg_fft_len,
    input  logic [LEN_W-1:0]                cfg_dec_fac,
    input  logic                            cfg_valid,
    output logic                            cfg_ready,
    output logic                            cfg_err,
    input  logic [WIDTH*SAMP_PER_CLK-1:0]   s_data,
    input  logic                            s_valid,
    output logic                            s_ready,
    output logic [WIDTH*SAMP_PER_CLK-1:0]   m_data,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [LEN_W-1:0]                m_beat_idx,
    output logic                            m_frame_start,
    output logic                            m_frame_last,
    output logic [LEN_W-2:0]                m_shift,
    output logic [FCNT_W-1:0]               m_frame_cnt
);

    localparam int DW      = WIDTH * SAMP_PER_CLK;
    localparam int SPC_LOG = $clog2(SAMP_PER_CLK);

    localparam logic [LEN_W-1:0] SPC_L   = LEN_W'(SAMP_PER_CLK);
    localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(2 * SAMP_PER_CLK);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_FFT_LEN);
    localparam logic [LEN_W-1:0] DEF_LEN = LEN_W'(DEF_FFT_LEN);
    localparam logic [LEN_W-1:0] DEF_DEC = LEN_W'(DEF_DEC_FAC);
    localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);

    // Active configuration, pending configuration and frame counters
    logic [LEN_W-1:0]  fft_len_q, fft_len_d;
    logic [LEN_W-1:0]  dec_fac_q, dec_fac_d;
    logic [LEN_W-1:0]  pend_len_q, pend_len_d;
    logic [LEN_W-1:0]  pend_dec_q, pend_dec_d;
    logic              pending_q, pending_d;
    logic              cfg_err_q, cfg_err_d;
    logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [LEN_W-2:0]  shift_q, shift_d;
    logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;

    // Output register stage
    logic [DW-1:0]     m_data_q, m_data_d;
    logic              m_valid_q, m_valid_d;
    logic [LEN_W-1:0]  m_beat_idx_q, m_beat_idx_d;
    logic              m_frame_start_q, m_frame_start_d;
    logic              m_frame_last_q, m_frame_last_d;
    logic [LEN_W-2:0]  m_shift_q, m_shift_d;
    logic [FCNT_W-1:0] m_frame_cnt_q, m_frame_cnt_d;

    // Handshake, frame-position and config-legality terms
    logic              beat_acc;
    logic              cfg_acc;
    logic [LEN_W-1:0]  last_idx;
    logic              is_last;
    logic              boundary;
    logic              apply;
    logic [LEN_W-1:0]  shift_sum;
    logic [LEN_W-1:0]  shift_wrap;
    logic              len_ok;
    logic              dec_ok;

    // Derive handshakes, the frame boundary and the next circular shift
    always_comb begin
        s_ready   = !m_valid_q || m_ready;
        beat_acc  = s_valid && s_ready;
        cfg_acc   = cfg_valid && !pending_q;
        last_idx  = (dec_fac_q >> SPC_LOG) - ONE_L;
        is_last   = (beat_cnt_q == last_idx);
        boundary  = (beat_acc && is_last) || (!beat_acc && (beat_cnt_q == '0));
        apply     = pending_q && boundary;
        // shift < M and D <= M, so one conditional subtract keeps it in 0..M-1
        shift_sum = {1'b0, shift_q} + dec_fac_q;
        if (shift_sum >= fft_len_q) begin
            shift_wrap = shift_sum - fft_len_q;
        end else begin
            shift_wrap = shift_sum;
        end
        len_ok = (cfg_fft_len != '0)
              && ((cfg_fft_len & (cfg_fft_len - ONE_L)) == '0)
              && (cfg_fft_len >= MIN_LEN)
              && (cfg_fft_len <= MAX_LEN);
        dec_ok = (cfg_dec_fac != '0)
              && ((cfg_dec_fac & (SPC_L - ONE_L)) == '0)
              && (cfg_dec_fac <= cfg_fft_len);
    end

    // Next-state for config capture, beat/shift/frame counters and config apply
    always_comb begin
        fft_len_d   = fft_len_q;
        dec_fac_d   = dec_fac_q;
        pend_len_d  = pend_len_q;
        pend_dec_d  = pend_dec_q;
        pending_d   = pending_q;
        cfg_err_d   = cfg_err_q;
        beat_cnt_d  = beat_cnt_q;
        shift_d     = shift_q;
        frame_cnt_d = frame_cnt_q;

        if (cfg_acc) begin
            if (len_ok && dec_ok) begin
                pend_len_d = cfg_fft_len;
                pend_dec_d = cfg_dec_fac;
                pending_d  = 1'b1;
                cfg_err_d  = 1'b0;
            end else begin
                cfg_err_d  = 1'b1;
            end
        end

        if (beat_acc) begin
            if (is_last) begin
                beat_cnt_d  = '0;
                shift_d     = shift_wrap[LEN_W-2:0];
                frame_cnt_d = frame_cnt_q + FCNT_W'(1);
            end else begin
                beat_cnt_d  = beat_cnt_q + ONE_L;
            end
        end

        // apply needs pending_q, cfg_acc needs !pending_q: they never collide
        if (apply) begin
            fft_len_d   = pend_len_q;
            dec_fac_d   = pend_dec_q;
            beat_cnt_d  = '0;
            shift_d     = '0;
            frame_cnt_d = '0;
            pending_d   = 1'b0;
        end
    end

    // Next-state for the output stage: load on accept, drop valid once drained
    always_comb begin
        m_data_d        = m_data_q;
        m_valid_d       = m_valid_q;
        m_beat_idx_d    = m_beat_idx_q;
        m_frame_start_d = m_frame_start_q;
        m_frame_last_d  = m_frame_last_q;
        m_shift_d       = m_shift_q;
        m_frame_cnt_d   = m_frame_cnt_q;

        if (beat_acc) begin
            m_data_d        = s_data;
            m_valid_d       = 1'b1;
            m_beat_idx_d    = beat_cnt_q;
            m_frame_start_d = (beat_cnt_q == '0);
            m_frame_last_d  = is_last;
            m_shift_d       = shift_q;
            m_frame_cnt_d   = frame_cnt_q;
        end else if (m_ready) begin
            m_valid_d       = 1'b0;
        end
    end

    // Control-state register with asynchronous active-low reset to defaults
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fft_len_q   <= DEF_LEN;
            dec_fac_q   <= DEF_DEC;
            pend_len_q  <= '0;
            pend_dec_q  <= '0;
            pending_q   <= 1'b0;
            cfg_err_q   <= 1'b0;
            beat_cnt_q  <= '0;
            shift_q     <= '0;
            frame_cnt_q <= '0;
        end else begin
            fft_len_q   <= fft_len_d;
            dec_fac_q   <= dec_fac_d;
            pend_len_q  <= pend_len_d;
            pend_dec_q  <= pend_dec_d;
            pending_q   <= pending_d;
            cfg_err_q   <= cfg_err_d;
            beat_cnt_q  <= beat_cnt_d;
            shift_q     <= shift_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Output register with asynchronous active-low reset to all zeros
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data_q        <= '0;
            m_valid_q       <= 1'b0;
            m_beat_idx_q    <= '0;
            m_frame_start_q <= 1'b0;
            m_frame_last_q  <= 1'b0;
            m_shift_q       <= '0;
            m_frame_cnt_q   <= '0;
        end else begin
            m_data_q        <= m_data_d;
            m_valid_q       <= m_valid_d;
            m_beat_idx_q    <= m_beat_idx_d;
            m_frame_start_q <= m_frame_start_d;
            m_frame_last_q  <= m_frame_last_d;
            m_shift_q       <= m_shift_d;
            m_frame_cnt_q   <= m_frame_cnt_d;
        end
    end

    assign cfg_ready     = !pending_q;
    assign cfg_err       = cfg_err_q;
    assign m_data        = m_data_q;
    assign m_valid       = m_valid_q;
    assign m_beat_idx    = m_beat_idx_q;
    assign m_frame_start = m_frame_start_q;
    assign m_frame_last  = m_frame_last_q;
    assign m_shift       = m_shift_q;
    assign m_frame_cnt   = m_frame_cnt_q;

endmodule

// File: tb/tb_ospfb_phase_sequencer.sv
// Directed bench for ospfb_phase_sequencer using default parameters
// (M=2048, D=1536, two samples per beat -> 768 beats per frame).
module tb_ospfb_phase_sequencer;

    localparam int LEN_W  = 13;
    localparam int DW     = 32;
    localparam int FCNT_W = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [LEN_W-1:0]  cfg_fft_len = '0;
    logic [LEN_W-1:0]  cfg_dec_fac = '0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic              cfg_err;
    logic [DW-1:0]     s_data = '0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [DW-1:0]     m_data;
    logic              m_valid;
    logic              m_ready = 1'b1;
    logic [LEN_W-1:0]  m_beat_idx;
    logic              m_frame_start;
    logic              m_frame_last;
    logic [LEN_W-2:0]  m_shift;
    logic [FCNT_W-1:0] m_frame_cnt;

    int errorCount = 0;
    int checkCount = 0;
    int sendCnt = 0;
    int outCnt = 0;
    int expIdx = 0;
    int expLen = 768;
    int nextLen = 768;
    int frameBase = 0;
    bit randomMode = 1'b0;
    int shiftQ[$];
    int cntQ[$];

    int t1Shift[5] = '{0, 1536, 1024, 512, 0};
    int t4Shift[6] = '{0, 1536, 0, 384, 256, 128};
    int t4Cnt[6]   = '{0, 1, 0, 1, 2, 3};

    ospfb_phase_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_fft_len   (cfg_fft_len),
        .cfg_dec_fac   (cfg_dec_fac),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_err       (cfg_err),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_beat_idx    (m_beat_idx),
        .m_frame_start (m_frame_start),
        .m_frame_last  (m_frame_last),
        .m_shift       (m_shift),
        .m_frame_cnt   (m_frame_cnt)
    );

    // 100 MHz DSP clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    // Downstream ready: always 1, or a fair coin per cycle while randomMode is set
    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_ready = randomMode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: checks every transferred beat and stability while stalled
    initial begin
        bit stalled;
        logic [DW-1:0] snapData;
        logic [LEN_W-1:0] snapIdx;
        logic [LEN_W-2:0] snapShift;
        stalled = 1'b0;
        snapData = '0;
        snapIdx = '0;
        snapShift = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                expIdx = 0;
                expLen = 768;
                outCnt = sendCnt;
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    checkOutput("stall_valid", 64'(m_valid), 64'd1);
                    checkOutput("stall_data", 64'(m_data), 64'(snapData));
                    checkOutput("stall_idx", 64'(m_beat_idx), 64'(snapIdx));
                    checkOutput("stall_shift", 64'(m_shift), 64'(snapShift));
                end
                if (m_valid && m_ready) begin
                    if (expIdx == 0) begin
                        expLen = nextLen;
                        shiftQ.push_back(int'(m_shift));
                        cntQ.push_back(int'(m_frame_cnt));
                    end
                    checkOutput("data", 64'(m_data), 64'(outCnt));
                    checkOutput("beat_idx", 64'(m_beat_idx), 64'(expIdx));
                    checkOutput("frame_start", 64'(m_frame_start), 64'(expIdx == 0));
                    checkOutput("frame_last", 64'(m_frame_last), 64'(expIdx == expLen - 1));
                    outCnt++;
                    expIdx = (expIdx == expLen - 1) ? 0 : expIdx + 1;
                end
                stalled = m_valid && !m_ready;
                snapData = m_data;
                snapIdx = m_beat_idx;
                snapShift = m_shift;
            end
        end
    end

    // Send n beats carrying an incrementing payload, bounded by a cycle budget
    task automatic applyStimulus(input int n);
        int got;
        int guard;
        bit acc;
        got = 0;
        guard = 0;
        while (got < n) begin
            s_valid = 1'b1;
            s_data = DW'(sendCnt);
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                sendCnt++;
                got++;
            end
            guard++;
            if (guard > 4 * n + 100) begin
                checkOutput("stim_timeout", 64'(got), 64'(n));
                break;
            end
        end
        s_valid = 1'b0;
    endtask

    // Present one config request and hold it until accepted (bounded)
    task automatic applyConfig(input int len, input int dec);
        int guard;
        bit acc;
        guard = 0;
        cfg_fft_len = LEN_W'(len);
        cfg_dec_fac = LEN_W'(dec);
        cfg_valid = 1'b1;
        acc = 1'b0;
        while (!acc) begin
            @(negedge clk);
            acc = cfg_ready;
            @(posedge clk);
            #1;
            guard++;
            if (!acc && guard > 5000) begin
                checkOutput("cfg_timeout", 64'd0, 64'd1);
                break;
            end
        end
        cfg_valid = 1'b0;
    endtask

    // Let any beat held in the output register drain
    task automatic drain();
        randomMode = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Assert reset mid-cycle, verify the asynchronous reset values, then release
    task automatic doReset();
        rst_n = 1'b0;
        #1;
        checkOutput("rst_m_valid", 64'(m_valid), 64'd0);
        checkOutput("rst_cfg_ready", 64'(cfg_ready), 64'd1);
        checkOutput("rst_cfg_err", 64'(cfg_err), 64'd0);
        checkOutput("rst_m_data", 64'(m_data), 64'd0);
        checkOutput("rst_beat_idx", 64'(m_beat_idx), 64'd0);
        checkOutput("rst_frame_start", 64'(m_frame_start), 64'd0);
        checkOutput("rst_frame_last", 64'(m_frame_last), 64'd0);
        checkOutput("rst_shift", 64'(m_shift), 64'd0);
        checkOutput("rst_frame_cnt", 64'(m_frame_cnt), 64'd0);
        nextLen = 768;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        frameBase = shiftQ.size();
    endtask

    task automatic checkFrame(input int k, input int expShift, input int expCnt);
        if (frameBase + k < shiftQ.size()) begin
            checkOutput("frame_shift", 64'(shiftQ[frameBase + k]), 64'(expShift));
            checkOutput("frame_cnt", 64'(cntQ[frameBase + k]), 64'(expCnt));
        end else begin
            checkOutput("frame_present", 64'd0, 64'd1);
        end
    endtask

    initial begin
        #12;

        // Defaults with continuous flow: 5 frames of 768 beats
        doReset();
        applyStimulus(3840);
        drain();
        checkOutput("t1_frames", 64'(shiftQ.size() - frameBase), 64'd5);
        for (int i = 0; i < 5; i++) checkFrame(i, t1Shift[i], i);

        // Same stream under random backpressure
        doReset();
        randomMode = 1'b1;
        applyStimulus(3840);
        drain();
        checkOutput("t2_frames", 64'(shiftQ.size() - frameBase), 64'd5);
        for (int i = 0; i < 5; i++) checkFrame(i, t1Shift[i], i);
        checkOutput("t2_all_out", 64'(outCnt), 64'(sendCnt));

        // Mid-frame config waits for the end of the 768-beat frame
        doReset();
        applyStimulus(100);
        applyConfig(1024, 1024);
        nextLen = 512;
        checkOutput("t3_ready_low", 64'(cfg_ready), 64'd0);
        checkOutput("t3_err", 64'(cfg_err), 64'd0);
        applyStimulus(667);
        checkOutput("t3_ready_still_low", 64'(cfg_ready), 64'd0);
        applyStimulus(1);
        checkOutput("t3_ready_high", 64'(cfg_ready), 64'd1);
        applyStimulus(1024);
        drain();
        checkOutput("t3_frames", 64'(shiftQ.size() - frameBase), 64'd3);
        checkFrame(0, 0, 0);
        checkFrame(1, 0, 0);
        checkFrame(2, 0, 1);

        // Illegal configs are rejected, then a legal one applied while idle
        doReset();
        applyConfig(1000, 512);
        checkOutput("t4_err_len", 64'(cfg_err), 64'd1);
        checkOutput("t4_ready_len", 64'(cfg_ready), 64'd1);
        applyConfig(1024, 3);
        checkOutput("t4_err_dec", 64'(cfg_err), 64'd1);
        checkOutput("t4_ready_dec", 64'(cfg_ready), 64'd1);
        applyStimulus(1536);
        applyConfig(512, 384);
        nextLen = 192;
        checkOutput("t6_err_clear", 64'(cfg_err), 64'd0);
        checkOutput("t6_ready_low", 64'(cfg_ready), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("t6_ready_high", 64'(cfg_ready), 64'd1);
        applyStimulus(768);
        drain();
        checkOutput("t4_frames", 64'(shiftQ.size() - frameBase), 64'd6);
        for (int i = 0; i < 6; i++) checkFrame(i, t4Shift[i], t4Cnt[i]);

        // Asynchronous reset at beat 300 of frame 2 with a beat in flight
        doReset();
        applyStimulus(1836);
        applyConfig(1024, 1024);
        checkOutput("t5_pending", 64'(cfg_ready), 64'd0);
        applyStimulus(1);
        checkOutput("t5_in_flight", 64'(m_valid), 64'd1);
        doReset();
        applyStimulus(768);
        drain();
        checkOutput("t5_frames", 64'(shiftQ.size() - frameBase), 64'd1);
        checkFrame(0, 0, 0);
        checkOutput("t5_all_out", 64'(outCnt), 64'(sendCnt));

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
